// File: rtl/node_port_writer.sv
// Transmit side of the inter-node port channel: saturates a core write and
// offers it to one neighbour (or all four) until a reader accepts it.
module node_port_writer #(
    parameter int DATA_W  = 11,
    parameter int MAX_VAL = 999
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_req,
    input  logic [2:0]               wr_dir,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_busy,
    output logic                     wr_done,
    output logic [1:0]               wr_taken_dir,
    output logic [3:0]               out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [3:0]               out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        DONE
    } state_t;

    localparam logic signed [DATA_W-1:0] POS = DATA_W'(MAX_VAL);
    localparam logic signed [DATA_W-1:0] NEG = -POS;

    state_t                     state;
    state_t                     state_nx;
    logic [2:0]                 dir_q;
    logic signed [DATA_W-1:0]   data_q;
    logic [1:0]                 taken_q;
    logic signed [DATA_W-1:0]   sat;
    logic [3:0]                 hit;
    logic [1:0]                 win;

    always_comb begin
        sat = wr_data;
        if (wr_data > POS) begin
            sat = POS;
        end else if (wr_data < NEG) begin
            sat = NEG;
        end
    end

    // Decoded from state so an async reset drops the offer at once.
    always_comb begin
        out_valid = 4'b0000;
        if (state == OFFER) begin
            if (dir_q == 3'd4) begin
                out_valid = 4'b1111;
            end else if (dir_q < 3'd4) begin
                out_valid = 4'b0001 << dir_q[1:0];
            end
        end
    end

    assign hit = out_valid & out_ready;

    // Lowest index wins when several neighbours accept an ANY offer.
    always_comb begin
        win = 2'd0;
        if (hit[0]) begin
            win = 2'd0;
        end else if (hit[1]) begin
            win = 2'd1;
        end else if (hit[2]) begin
            win = 2'd2;
        end else if (hit[3]) begin
            win = 2'd3;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nx = (wr_dir > 3'd4) ? DONE : OFFER;
                end
            end
            OFFER: begin
                if (|hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            dir_q   <= 3'd0;
            data_q  <= '0;
            taken_q <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && wr_req) begin
                dir_q  <= wr_dir;
                data_q <= sat;
            end
            if (state == OFFER && |hit) begin
                taken_q <= win;
            end
        end
    end

    assign wr_busy      = (state != IDLE) || wr_req;
    assign wr_done      = (state == DONE);
    assign wr_taken_dir = taken_q;
    assign out_data     = data_q;

endmodule
